// File: rtl/me_stage_mem_pkg.sv
// Shared encodings for the ME stage: memory access types, WB source selects
// and the default data-memory depth.
package me_stage_mem_pkg;

  localparam logic [2:0] MEMOP_W  = 3'b000;
  localparam logic [2:0] MEMOP_HS = 3'b001;
  localparam logic [2:0] MEMOP_HU = 3'b010;
  localparam logic [2:0] MEMOP_BS = 3'b011;
  localparam logic [2:0] MEMOP_BU = 3'b100;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC8 = 2'b10;

  localparam int DM_WORDS_DEF = 3072;

endpackage

// File: rtl/me_stage_mem_if.sv
// EX/ME input bundle and ME/WB output bundle of the memory stage.
// master drives the ME side and observes W; slave is the ME stage itself.
interface me_stage_mem_if;

  logic        CheckM;
  logic [31:0] PCM;
  logic        RegWriteM;
  logic [1:0]  TnewM;
  logic [1:0]  RegSrcM;
  logic [4:0]  RegDstM;
  logic [31:0] ResultM;
  logic [31:0] WriteDataM;
  logic        MemWriteM;
  logic [2:0]  MemOpM;

  logic        CheckW;
  logic [31:0] PCW;
  logic        RegWriteW;
  logic [1:0]  TnewW;
  logic [1:0]  RegSrcW;
  logic [4:0]  RegDstW;
  logic [31:0] ResultW;
  logic [31:0] ReadDataW;

  modport master (
    output CheckM, PCM, RegWriteM, TnewM, RegSrcM, RegDstM,
           ResultM, WriteDataM, MemWriteM, MemOpM,
    input  CheckW, PCW, RegWriteW, TnewW, RegSrcW, RegDstW,
           ResultW, ReadDataW
  );

  modport slave (
    input  CheckM, PCM, RegWriteM, TnewM, RegSrcM, RegDstM,
           ResultM, WriteDataM, MemWriteM, MemOpM,
    output CheckW, PCW, RegWriteW, TnewW, RegSrcW, RegDstW,
           ResultW, ReadDataW
  );

endinterface

// File: rtl/me_stage_mem_load_ext.sv
// Load lane select and sign/zero extension of a 32-bit memory word.
module me_load_ext
  import me_stage_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  memop,
  output logic [31:0] data
);

  logic [15:0] h16;
  logic [7:0]  b8;

  always_comb begin
    h16 = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    b8 = word[7:0];
      2'd1:    b8 = word[15:8];
      2'd2:    b8 = word[23:16];
      default: b8 = word[31:24];
    endcase
    case (memop)
      MEMOP_HS: data = {{16{h16[15]}}, h16};
      MEMOP_HU: data = {16'h0000, h16};
      MEMOP_BS: data = {{24{b8[7]}}, b8};
      MEMOP_BU: data = {24'h000000, b8};
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/me_stage_mem.sv
// ME stage: data-memory access plus the ME/WB pipeline register.
// Define ME_STORE_LOG_EN to print one line per committed store in simulation.
module me_stage_mem
  import me_stage_mem_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW    = 12
) (
  input logic           clk,
  input logic           reset,
  me_stage_mem_if.slave bus
);

  logic [31:0]      mem [DM_WORDS];
  logic [DM_AW-1:0] idx_p0;
  logic [1:0]       lane_p0;
  logic             in_range_p0;
  logic             aligned_p0;
  logic             wr_en_p0;
  logic [3:0]       be_p0;
  logic [31:0]      wdata_p0;
  logic [31:0]      rd_word_p0;
  logic [31:0]      merged_p0;
  logic [31:0]      ld_ext_p0;
  logic [31:0]      ld_data_p0;

  logic        check_p1;
  logic [31:0] pc_p1;
  logic        regwrite_p1;
  logic [1:0]  tnew_p1;
  logic [1:0]  regsrc_p1;
  logic [4:0]  regdst_p1;
  logic [31:0] result_p1;
  logic [31:0] rdata_p1;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  always_comb begin
    idx_p0      = bus.ResultM[DM_AW+1:2];
    lane_p0     = bus.ResultM[1:0];
    in_range_p0 = (bus.ResultM[31:DM_AW+2] == '0) && (32'(idx_p0) < 32'(DM_WORDS));
    case (bus.MemOpM)
      MEMOP_HS, MEMOP_HU: begin
        aligned_p0 = ~lane_p0[0];
        be_p0      = lane_p0[1] ? 4'b1100 : 4'b0011;
        wdata_p0   = {2{bus.WriteDataM[15:0]}};
      end
      MEMOP_BS, MEMOP_BU: begin
        aligned_p0 = 1'b1;
        be_p0      = 4'b0001 << lane_p0;
        wdata_p0   = {4{bus.WriteDataM[7:0]}};
      end
      default: begin
        aligned_p0 = (lane_p0 == 2'd0);
        be_p0      = 4'b1111;
        wdata_p0   = bus.WriteDataM;
      end
    endcase
    rd_word_p0 = in_range_p0 ? mem[idx_p0] : '0;
    wr_en_p0   = bus.MemWriteM && in_range_p0 && aligned_p0;
    for (int l = 0; l < 4; l++) begin
      merged_p0[8*l +: 8] = be_p0[l] ? wdata_p0[8*l +: 8] : rd_word_p0[8*l +: 8];
    end
    ld_data_p0 = (in_range_p0 && aligned_p0) ? ld_ext_p0 : '0;
  end

  me_load_ext u_load_ext (
    .word  (rd_word_p0),
    .lane  (lane_p0),
    .memop (bus.MemOpM),
    .data  (ld_ext_p0)
  );

  // Memory write commits on the same edge that moves the instruction to W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else if (wr_en_p0) begin
      mem[idx_p0] <= merged_p0;
    end
  end

`ifdef ME_STORE_LOG_EN
  always @(posedge clk) begin
    if (reset && wr_en_p0)
      $display("%0t@%h: *%h <= %h", $time, bus.PCM, {bus.ResultM[31:2], 2'b00}, merged_p0);
  end
`else
`endif

  // ME -> W stage boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      check_p1    <= 1'b0;
      pc_p1       <= '0;
      regwrite_p1 <= 1'b0;
      tnew_p1     <= '0;
      regsrc_p1   <= '0;
      regdst_p1   <= '0;
      result_p1   <= '0;
      rdata_p1    <= '0;
    end else begin
      check_p1    <= bus.CheckM;
      pc_p1       <= bus.PCM;
      regwrite_p1 <= bus.RegWriteM;
      tnew_p1     <= tnew_dec(bus.TnewM);
      regsrc_p1   <= bus.RegSrcM;
      regdst_p1   <= bus.RegDstM;
      result_p1   <= bus.ResultM;
      rdata_p1    <= ld_data_p0;
    end
  end

  assign bus.CheckW    = check_p1;
  assign bus.PCW       = pc_p1;
  assign bus.RegWriteW = regwrite_p1;
  assign bus.TnewW     = tnew_p1;
  assign bus.RegSrcW   = regsrc_p1;
  assign bus.RegDstW   = regdst_p1;
  assign bus.ResultW   = result_p1;
  assign bus.ReadDataW = rdata_p1;

endmodule

// File: tb/tb_me_stage_mem.sv
// Scoreboard bench for me_stage_mem: byte-array memory model, directed and
// random memory ops, synchronous and asynchronous reset.
module tb_me_stage_mem;
  import me_stage_mem_pkg::*;

  localparam int DMW = 3072;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  me_stage_mem_if bus ();

  me_stage_mem #(.DM_WORDS(DMW), .DM_AW(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        chk;
    logic [31:0] pc;
    logic        rw;
    logic [1:0]  tn;
    logic [1:0]  src;
    logic [4:0]  dst;
    logic [31:0] res;
    logic [31:0] rd;
  } wb_t;

  typedef struct {
    wb_t exp;
    int  cyc;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    nvec = 0;
  int    nerr = 0;
  logic [7:0] mb [DMW*4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic wb_t actual();
    return {bus.CheckW, bus.PCW, bus.RegWriteW, bus.TnewW, bus.RegSrcW,
            bus.RegDstW, bus.ResultW, bus.ReadDataW};
  endfunction

  function automatic int size_of(input logic [2:0] op);
    if (op == MEMOP_HS || op == MEMOP_HU) return 2;
    if (op == MEMOP_BS || op == MEMOP_BU) return 1;
    return 4;
  endfunction

  function automatic bit usable(input logic [31:0] addr, input logic [2:0] op);
    return (addr < 32'(DMW*4)) && (addr % 32'(size_of(op)) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] op);
    logic [31:0] v;
    int n;
    n = size_of(op);
    v = '0;
    if (!usable(addr, op)) return '0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[addr + 32'(i)]) << (8*i));
    if (op == MEMOP_HS && v[15]) v = v | 32'hFFFF0000;
    if (op == MEMOP_BS && v[7])  v = v | 32'hFFFFFF00;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] d);
    if (usable(addr, op))
      for (int i = 0; i < size_of(op); i++) mb[addr + 32'(i)] = 8'(d >> (8*i));
  endtask

  task automatic chk(input string name, input wb_t got, input wb_t exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [31:0] pc, input logic rw,
                       input logic [1:0] tn, input logic [1:0] src, input logic [4:0] dst,
                       input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input bit has_k, input logic [31:0] k);
    item_t it;
    bus.CheckM = c;  bus.PCM = pc;  bus.RegWriteM = rw; bus.TnewM = tn;
    bus.RegSrcM = src; bus.RegDstM = dst; bus.ResultM = addr;
    bus.WriteDataM = wd; bus.MemWriteM = we; bus.MemOpM = op;
    it.exp.chk = c;  it.exp.pc = pc; it.exp.rw = rw;
    it.exp.tn  = (tn == 2'd0) ? 2'd0 : tn - 2'd1;
    it.exp.src = src; it.exp.dst = dst; it.exp.res = addr;
    it.exp.rd  = has_k ? k : ref_load(addr, op);
    if (we) ref_store(addr, op, wd);
    it.cyc = cyc;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic mop(input logic we, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wd, input bit has_k, input logic [31:0] k);
    drive(1'($urandom), $urandom, 1'($urandom), 2'($urandom), 2'($urandom),
          5'($urandom), we, op, addr, wd, has_k, k);
  endtask

  task automatic zero_inputs();
    bus.CheckM = 0; bus.PCM = '0; bus.RegWriteM = 0; bus.TnewM = '0;
    bus.RegSrcM = '0; bus.RegDstM = '0; bus.ResultM = '0;
    bus.WriteDataM = '0; bus.MemWriteM = 0; bus.MemOpM = '0;
  endtask

  // Scoreboard monitor: compares each bundle one edge after it was issued
  always @(negedge clk) begin
    if (reset === 1'b1 && q.size() > 0 && q[0].cyc < cyc) begin
      item_t it;
      it = q.pop_front();
      chk("wb_bundle", actual(), it.exp);
    end
  end

  initial begin
    logic [31:0] a;
    reset = 1'b0;
    zero_inputs();
    for (int i = 0; i < DMW*4; i++) mb[i] = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", actual(), '0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;

    mop(1, MEMOP_W, 32'h0, 32'h00000055, 0, '0);
    mop(1, MEMOP_W, 32'h10, 32'h12345678, 0, '0);
    mop(0, MEMOP_W, 32'h10, '0, 1, 32'h12345678);
    mop(1, MEMOP_W, 32'h20, 32'hAABBCCDD, 0, '0);
    mop(1, MEMOP_BU, 32'h21, 32'hFFFFFF11, 0, '0);
    mop(0, MEMOP_W,  32'h20, '0, 1, 32'hAABB11DD);
    mop(0, MEMOP_HS, 32'h22, '0, 1, 32'hFFFFAABB);
    mop(0, MEMOP_HU, 32'h22, '0, 1, 32'h0000AABB);
    mop(0, MEMOP_BU, 32'h23, '0, 1, 32'h000000AA);
    drive(1, 32'h3004, 1, 2'd2, SRC_ALU, 5'd1, 0, MEMOP_W, 32'h0, '0, 0, '0);
    drive(1, 32'h3008, 1, 2'd1, SRC_MEM, 5'd2, 0, MEMOP_W, 32'h0, '0, 0, '0);
    drive(1, 32'h300C, 1, 2'd0, SRC_ALU, 5'd3, 0, MEMOP_W, 32'h0, '0, 0, '0);
    drive(1, 32'h3000, 1, 2'd0, SRC_PC8, 5'd31, 0, MEMOP_W, 32'h0, '0, 0, '0);
    mop(1, MEMOP_W, 32'h3000, 32'hDEADBEEF, 0, '0);
    mop(0, MEMOP_W, 32'h3000, '0, 1, 32'h0);
    mop(1, MEMOP_W, 32'h2FFC, 32'h0BADF00D, 0, '0);
    mop(0, MEMOP_W, 32'h2FFC, '0, 1, 32'h0BADF00D);
    mop(1, MEMOP_HU, 32'h21, 32'h0000BEEF, 0, '0);
    mop(0, MEMOP_W, 32'h20, '0, 1, 32'hAABB11DD);
    mop(1, MEMOP_W, 32'h00010010, 32'hFEEDFACE, 0, '0);
    mop(0, MEMOP_W, 32'h10, '0, 1, 32'h12345678);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h2FF0 + 32'($urandom_range(0, 31));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      mop(1'($urandom), 3'($urandom), a, $urandom, 0, '0);
    end

    // Asynchronous reset between edges while a store is presented
    drive(1, 32'h3000, 1, 2'd2, SRC_PC8, 5'd31, 1, MEMOP_W, 32'h40, 32'h01020304, 0, '0);
    @(negedge clk);
    #1;
    bus.MemWriteM = 1; bus.MemOpM = MEMOP_W; bus.ResultM = 32'h44;
    bus.WriteDataM = 32'hCAFEBABE; bus.PCM = 32'h1234; bus.CheckM = 1;
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_drop", actual(), '0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", actual(), '0);
    end
    zero_inputs();
    q.delete();
    for (int i = 0; i < DMW*4; i++) mb[i] = 8'h00;
    reset = 1'b1;
    @(posedge clk);
    #1;
    mop(0, MEMOP_W, 32'h0,  '0, 1, 32'h0);
    mop(0, MEMOP_W, 32'h40, '0, 1, 32'h0);
    mop(0, MEMOP_W, 32'h44, '0, 1, 32'h0);
    mop(0, MEMOP_W, 32'h10, '0, 1, 32'h0);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
